mux1: RTL and testbench

MUX1 -- requirements
Module: mux1

---
 rtl/mux_pkg.sv | 8 +
 rtl/mux4_bit.sv | 18 +
 rtl/mux1.sv | 27 ++
 tb/tb_mux1.sv | 82 ++++++++
 4 files changed

// File: rtl/mux_pkg.sv
// mux_pkg: shared width default and select codes for the mux1 slice
package mux_pkg;
  localparam int WIDTH_DEF = 5;
  localparam logic [1:0] SEL_S1 = 2'b00;
  localparam logic [1:0] SEL_S2 = 2'b01;
  localparam logic [1:0] SEL_S3 = 2'b10;
  localparam logic [1:0] SEL_S4 = 2'b11;
endpackage

// File: rtl/mux4_bit.sv
// mux4_bit: 1-bit 4:1 mux built from AND/OR/NOT primitives so X/Z propagate naturally
module mux4_bit (
  input  logic [1:0] select,
  input  logic       d0,
  input  logic       d1,
  input  logic       d2,
  input  logic       d3,
  output logic       y
);
  logic n0, n1, a0, a1, a2, a3;
  not g_n0 (n0, select[0]);
  not g_n1 (n1, select[1]);
  and g_a0 (a0, d0, n1, n0);
  and g_a1 (a1, d1, n1, select[0]);
  and g_a2 (a2, d2, select[1], n0);
  and g_a3 (a3, d3, select[1], select[0]);
  or  g_o  (y, a0, a1, a2, a3);
endmodule

// File: rtl/mux1.sv
// mux1: registered WIDTH-bit 4:1 mux, one-cycle latency, synchronous active-high reset
module mux1 import mux_pkg::*; #(
  parameter int WIDTH = WIDTH_DEF
) (
  input  logic             clk,
  input  logic             reset,
  output logic [WIDTH-1:0] result,
  input  logic [1:0]       select,
  input  logic [WIDTH-1:0] s1,
  input  logic [WIDTH-1:0] s2,
  input  logic [WIDTH-1:0] s3,
  input  logic [WIDTH-1:0] s4
);
  logic [WIDTH-1:0] sel_data;
  for (genvar i = 0; i < WIDTH; i++) begin : g_bit
    mux4_bit u_bit (
      .select(select),
      .d0(s1[i]),
      .d1(s2[i]),
      .d2(s3[i]),
      .d3(s4[i]),
      .y(sel_data[i])
    );
  end
  always_ff @(posedge clk)
    result <= reset ? '0 : sel_data;
endmodule

// File: tb/tb_mux1.sv
// tb_mux1: directed and random self-checking bench for mux1
module tb_mux1;
  import mux_pkg::*;
  localparam int W = WIDTH_DEF;
  logic clk = 1'b0;
  logic reset;
  logic [W-1:0] result;
  logic [1:0] select;
  logic [W-1:0] s1, s2, s3, s4;
  int vectors = 0;
  int miscompares = 0;

  mux1 #(.WIDTH(W)) dut (
    .clk(clk),
    .reset(reset),
    .result(result),
    .select(select),
    .s1(s1),
    .s2(s2),
    .s3(s3),
    .s4(s4)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  function automatic logic [W-1:0] ref_sel(input logic [1:0] sel, input logic [W-1:0] a, b, c, d);
    case (sel)
      SEL_S1:  return a;
      SEL_S2:  return b;
      SEL_S3:  return c;
      default: return d;
    endcase
  endfunction

  initial begin
    logic [W-1:0] exp;
    reset = 1'b1;
    select = SEL_S1;
    s1 = 5'b00001; s2 = 5'b00011; s3 = 5'b00111; s4 = 5'b01111;
    tick(); chk("reset_edge1", result, 5'b00000);
    tick(); chk("reset_edge2", result, 5'b00000);
    reset = 1'b0;
    tick(); chk("sweep_00", result, 5'b00001);
    select = SEL_S2; tick(); chk("sweep_01", result, 5'b00011);
    select = SEL_S3; tick(); chk("sweep_10", result, 5'b00111);
    select = SEL_S4; tick(); chk("sweep_11", result, 5'b01111);
    select = SEL_S3; tick(); chk("indep_base", result, 5'b00111);
    s3 = 5'b11000; tick(); chk("indep_s3", result, 5'b11000);
    s1 = 5'b10101; s2 = 5'b01010; s4 = 5'b11111;
    tick(); chk("indep_others", result, 5'b11000);
    s1 = 5'b00001; s2 = 5'b00011; s4 = 5'b01111;
    select = SEL_S4; tick(); chk("midrst_pre", result, 5'b01111);
    reset = 1'b1; tick(); chk("midrst_on", result, 5'b00000);
    reset = 1'b0; tick(); chk("midrst_off", result, 5'b01111);
    select = SEL_S1; #3; chk("between_select", result, 5'b01111);
    reset = 1'b1; #1; chk("between_reset", result, 5'b01111);
    reset = 1'b0;
    tick(); chk("between_edge", result, 5'b00001);
    select = SEL_S2; s2 = 5'b10110; tick(); chk("simul_change", result, 5'b10110);
    for (int n = 0; n < 1000; n++) begin
      select = 2'($urandom_range(0, 3));
      s1 = W'($urandom); s2 = W'($urandom); s3 = W'($urandom); s4 = W'($urandom);
      exp = ref_sel(select, s1, s2, s3, s4);
      tick(); chk("random", result, exp);
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
